// File: rtl/mem_init_pkg.sv
// Shared constants for the burst memory initiator.
// Holds default widths and the FSM state encoding.
package mem_init_pkg;

  localparam int MI_ADDR_W = 4;
  localparam int MI_DATA_W = 8;
  localparam int MI_LEN_W  = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_WRITE    = 2'd1;
  localparam state_t ST_RD_ISSUE = 2'd2;
  localparam state_t ST_RD_WAIT  = 2'd3;

endpackage

// File: rtl/mem_initiator.sv
// Burst initiator driving a registered-output 16x8 memory.
// Ports: clk/reset, cmd_* command, wd_* write beats,
// rd_* read beats, done pulse, mem_* memory port.
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = MI_ADDR_W,
  parameter int DATA_W = MI_DATA_W,
  parameter int LEN_W  = MI_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  input  logic [DATA_W-1:0] wd_data,
  output logic              wd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          beats_d = cmd_len;
          state_d = cmd_write ? ST_WRITE : ST_RD_ISSUE;
        end
      end
      ST_WRITE: begin
        if (wd_valid) begin
          if (beats_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            beats_d = beats_q - 1'b1;
          end
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_ready) begin
          if (beats_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            beats_d = beats_q - 1'b1;
            state_d = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      done_q  <= done_d;
    end
  end

  // mem_rd drops in RD_WAIT so the memory holds dout
  // for as long as the reader backpressures.
  assign cmd_ready = (state_q == ST_IDLE);
  assign wd_ready  = (state_q == ST_WRITE);
  assign mem_wr    = (state_q == ST_WRITE) && wd_valid;
  assign mem_rd    = (state_q == ST_RD_ISSUE);
  assign rd_valid  = (state_q == ST_RD_WAIT);
  assign rd_data   = mem_dout;
  assign mem_din   = wd_data;
  assign mem_addr  = addr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized self-checking bench for mem_initiator.
// A 16x8 memory model is the responder; a shadow array is the reference.
module tb_mem_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wd_valid, wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done;
  logic [3:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic       mem_wr, mem_rd;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic [7:0] wbuf [16];

  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  int done_seen = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  mem_initiator dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_data(wd_data),
    .wd_ready(wd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready),
    .done(done),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (reset && done) done_seen++;
  end

  always @(negedge clk) begin
    if (mem_wr && mem_rd) overlap++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a,
                          input logic [3:0] len,
                          input int stall_pct,
                          input int st_beat,
                          input int st_n,
                          input bit pend,
                          input logic [3:0] pa,
                          input logic [3:0] plen);
    logic [3:0] cur;
    int nst;
    cur = a;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = a;
    cmd_len = len;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("done_clear", done, 0);
    @(negedge clk);
    cmd_valid = pend;
    cmd_write = 1'b0;
    cmd_addr = pa;
    cmd_len = plen;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == st_beat) nst = st_n;
      else if (int'($urandom_range(99)) < stall_pct)
        nst = int'($urandom_range(1, 2));
      else nst = 0;
      for (int k = 0; k < nst; k++) begin
        wd_valid = 1'b0;
        #1;
        chk("wr_stall_memwr", mem_wr, 0);
        chk("wr_stall_addr", mem_addr, cur);
        chk("wr_stall_ready", wd_ready, 1);
        @(negedge clk);
      end
      wd_valid = 1'b1;
      wd_data = wbuf[b];
      #1;
      chk("wr_memwr", mem_wr, 1);
      chk("wr_addr", mem_addr, cur);
      chk("wr_din", mem_din, wbuf[b]);
      chk("wr_busy_cmd", cmd_ready, 0);
      chk("wr_no_rd", mem_rd, 0);
      ref_mem[cur] = wbuf[b];
      cur = cur + 4'd1;
      @(negedge clk);
    end
    wd_valid = 1'b0;
    if (!pend) cmd_valid = 1'b0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_idle_ready", cmd_ready, 1);
    chk("wr_idle_memwr", mem_wr, 0);
    exp_done++;
  endtask

  task automatic do_read(input logic [3:0] a,
                         input logic [3:0] len,
                         input int bp_pct,
                         input int st_beat,
                         input int st_n,
                         input bit skip);
    logic [3:0] cur;
    int nst;
    cur = a;
    if (!skip) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr = a;
      cmd_len = len;
      #1;
      chk("cmd_ready_idle", cmd_ready, 1);
      chk("done_clear", done, 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      #1;
      chk("rd_issue_memrd", mem_rd, 1);
      chk("rd_issue_valid", rd_valid, 0);
      chk("rd_issue_addr", mem_addr, cur);
      chk("rd_no_wr", mem_wr, 0);
      chk("rd_busy_cmd", cmd_ready, 0);
      if (b == 0) chk("rd_first_done", done, 0);
      @(negedge clk);
      if (b == st_beat) nst = st_n;
      else if (int'($urandom_range(99)) < bp_pct)
        nst = int'($urandom_range(1, 3));
      else nst = 0;
      for (int k = 0; k < nst; k++) begin
        rd_ready = 1'b0;
        #1;
        chk("rd_bp_valid", rd_valid, 1);
        chk("rd_bp_data", rd_data, ref_mem[cur]);
        chk("rd_bp_memrd", mem_rd, 0);
        @(negedge clk);
      end
      rd_ready = 1'b1;
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, ref_mem[cur]);
      @(negedge clk);
      rd_ready = 1'b0;
      cur = cur + 4'd1;
    end
    #1;
    chk("rd_done", done, 1);
    chk("rd_idle_ready", cmd_ready, 1);
    exp_done++;
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wd_valid = 1'b0;
    wd_data = '0;
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_memwr", mem_wr, 0);
    chk("rst_memrd", mem_rd, 0);
    chk("rst_wd_ready", wd_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    reset = 1'b1;

    // single write then read
    wbuf[0] = 8'hA5;
    do_write(4'd3, 4'd0, 0, -1, 0, 1'b0, 4'd0, 4'd0);
    do_read(4'd3, 4'd0, 0, -1, 0, 1'b0);
    chk("single_rd_mem", mem[3], 8'hA5);

    // wrapping burst
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    wbuf[3] = 8'h44;
    do_write(4'd14, 4'd3, 0, -1, 0, 1'b0, 4'd0, 4'd0);
    chk("wrap_m14", mem[14], 8'h11);
    chk("wrap_m15", mem[15], 8'h22);
    chk("wrap_m0", mem[0], 8'h33);
    chk("wrap_m1", mem[1], 8'h44);
    do_read(4'd14, 4'd3, 0, -1, 0, 1'b0);

    // read backpressure 5 cycles
    do_read(4'd14, 4'd1, 0, 1, 5, 1'b0);

    // write stall 3 cycles mid burst
    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
    do_write(4'd6, 4'd3, 0, 2, 3, 1'b0, 4'd0, 4'd0);
    do_read(4'd6, 4'd3, 0, -1, 0, 1'b0);

    // busy command queued behind a write burst
    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
    do_write(4'd9, 4'd2, 0, -1, 0, 1'b1, 4'd9, 4'd2);
    do_read(4'd9, 4'd2, 0, -1, 0, 1'b1);

    // reset after 2 of 4 write beats
    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 4'd5;
    cmd_len = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wd_valid = 1'b1;
      wd_data = wbuf[b];
      ref_mem[4'(5 + b)] = wbuf[b];
      @(negedge clk);
    end
    wd_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_wd_ready", wd_ready, 0);
    chk("mid_rst_memwr", mem_wr, 0);
    chk("mid_rst_memrd", mem_rd, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    do_read(4'd5, 4'd3, 0, -1, 0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      logic [3:0] a, l;
      a = 4'($urandom);
      l = 4'($urandom);
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        do_write(a, l, 30, -1, 0, 1'b0, 4'd0, 4'd0);
      end else begin
        do_read(a, l, 30, -1, 0, 1'b0);
      end
    end

    repeat (2) @(negedge clk);
    chk("done_count", done_seen, exp_done);
    chk("wr_rd_overlap", overlap, 0);
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameters: ADDR_W, 4, memory address width; DATA_W, 8, memory data width; LEN_W, 4, burst length field width.
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both high.
REQ-005 cmd_write  input  1  1 = burst write, 0 = burst read; cmd_addr  input  ADDR_W  start address; cmd_len  input  LEN_W  beats minus one (0..15).
REQ-006 wd_valid  input  1  write beat offered; wd_data  input  DATA_W  write beat; wd_ready  output  1  write beat taken when both high.
REQ-007 rd_valid  output  1  read beat offered; rd_data  output  DATA_W  read beat; rd_ready  input  1  read beat taken when both high.
REQ-008 done  output  1  one-cycle pulse after the last beat of a burst.
REQ-009 mem_addr  output  ADDR_W; mem_din  output  DATA_W; mem_wr  output  1; mem_rd  output  1; mem_dout  input  DATA_W: port to the 16x8 memory, which registers dout on the clk edge where rd is high.

Function
REQ-010 SHALL implement states IDLE, WRITE, RD_ISSUE, RD_WAIT.
REQ-011 cmd_ready SHALL equal (state == IDLE); no other handshake output depends on cmd_valid.
REQ-012 IDLE: on cmd_valid, SHALL latch cmd_addr into cur_addr, cmd_len into beats_left, and go to WRITE if cmd_write else RD_ISSUE.
REQ-013 WRITE: wd_ready = 1; mem_wr = wd_valid; mem_din = wd_data; mem_addr = cur_addr (combinational from state and registers).
REQ-014 WRITE handshake: if beats_left == 0 go IDLE and pulse done next cycle; else cur_addr++ and beats_left--.
REQ-015 RD_ISSUE: mem_rd = 1 and mem_addr = cur_addr for exactly one cycle; then go to RD_WAIT.
REQ-016 RD_WAIT: rd_valid = 1, rd_data = mem_dout, mem_rd = 0, so mem_dout holds stable under backpressure.
REQ-017 RD_WAIT handshake: if beats_left == 0 go IDLE and pulse done; else cur_addr++, beats_left--, go RD_ISSUE.
REQ-018 Latency: command accepted at cycle N; first mem_wr possible at N+1; first mem_rd at N+1; first rd_valid at N+2; reads sustain 1 beat per 2 cycles, writes 1 beat per cycle.
REQ-019 cur_addr SHALL wrap modulo 2^ADDR_W (15 -> 0) within a burst.
REQ-020 cmd_valid while not IDLE SHALL be ignored; the command stays pending until cmd_ready.
REQ-021 wd_valid low in WRITE SHALL stall with mem_wr = 0 and no state change; rd_ready low in RD_WAIT SHALL hold rd_valid/rd_data.
REQ-022 mem_wr and mem_rd SHALL never be high in the same cycle; both SHALL be 0 in IDLE.
REQ-023 done SHALL be registered, high exactly one cycle, coincident with state == IDLE.

Reset
REQ-024 reset low SHALL immediately force state IDLE, cur_addr 0, beats_left 0, done 0, and therefore mem_wr 0, mem_rd 0, wd_ready 0, rd_valid 0, cmd_ready 1.
REQ-025 reset mid-burst SHALL abandon the burst without a done pulse; already written beats remain written.

Structure
REQ-026 Package mem_init_pkg SHALL hold the state enumeration and the ADDR_W, DATA_W, LEN_W defaults.
REQ-027 No sub-module is required; the address/beat counter is inline. The bench SHALL instantiate the existing 16x8 memory as the responder.

Verification
REQ-028 Single write then read: write addr 3 len 0 data 0xA5, then read addr 3 len 0 -> rd_data 0xA5, one done pulse per command.
REQ-029 Write burst addr 14 len 3 data 0x11,0x22,0x33,0x44 -> memory locations 14,15,0,1 hold those values (wrap); read burst addr 14 len 3 returns the same order.
REQ-030 Read backpressure: hold rd_ready low 5 cycles in RD_WAIT -> rd_valid stays high, rd_data stable, mem_rd low throughout.
REQ-031 Write stall: deassert wd_valid for 3 cycles mid-burst -> mem_wr 0 in those cycles, no address advance, final contents correct.
REQ-032 Busy command: assert cmd_valid during a burst -> cmd_ready 0 until done; queued command starts the cycle after return to IDLE.
REQ-033 Reset mid-burst after 2 of 4 write beats -> outputs at reset values, no done, locations of beats 1-2 written, beats 3-4 untouched.
